// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier.
//   - state_t       : controller states (IDLE, RUN, DONE)
//   - digit_count   : number of radix-4 digits processed for an unsigned
//                     operand of the given width (one extra digit absorbs
//                     an operand MSB of 1)
//   - count_width   : width of the step counter
//   - CODE_*        : Booth recode triplets {x_high, x, x_low}
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int digit_count(input int width);
      return width / 2 + 1;
   endfunction

   function automatic int count_width(input int width);
      return $clog2(digit_count(width) + 1);
   endfunction

   // Recode triplets and the digit each one stands for
   localparam logic [2:0] CODE_P0  = 3'b000;  // +0
   localparam logic [2:0] CODE_P1A = 3'b001;  // +1
   localparam logic [2:0] CODE_P1B = 3'b010;  // +1
   localparam logic [2:0] CODE_P2  = 3'b011;  // +2
   localparam logic [2:0] CODE_M2  = 3'b100;  // -2
   localparam logic [2:0] CODE_M1A = 3'b101;  // -1
   localparam logic [2:0] CODE_M1B = 3'b110;  // -1
   localparam logic [2:0] CODE_M0  = 3'b111;  // -0

endpackage

// File: rtl/booth_seq_multiplier_encoder.sv
// Radix-4 Booth partial-product encoder (combinational).
//   x_high, x, x_low : recode triplet of the multiplier
//   y                : multiplicand, n bits unsigned
//   sign             : 1 for a negative digit (including -0)
//   pp               : |d|*y for positive digits, its one's complement for
//                      negative digits; the caller adds sign at the LSB
module Booth_Encoder
   import booth_pkg::*;
#(
   parameter int n = 8
) (
   input  logic         x_high,
   input  logic         x,
   input  logic         x_low,
   input  logic [n-1:0] y,
   output logic         sign,
   output logic [n:0]   pp
);

   logic [n:0] mag_s;
   logic       neg_s;

   // Digit magnitude and polarity from the recode triplet
   always_comb begin
      mag_s = {(n+1){1'b0}};
      neg_s = 1'b0;
      case ({x_high, x, x_low})
         CODE_P0:  begin mag_s = {(n+1){1'b0}}; neg_s = 1'b0; end
         CODE_P1A: begin mag_s = {1'b0, y};     neg_s = 1'b0; end
         CODE_P1B: begin mag_s = {1'b0, y};     neg_s = 1'b0; end
         CODE_P2:  begin mag_s = {y, 1'b0};     neg_s = 1'b0; end
         CODE_M2:  begin mag_s = {y, 1'b0};     neg_s = 1'b1; end
         CODE_M1A: begin mag_s = {1'b0, y};     neg_s = 1'b1; end
         CODE_M1B: begin mag_s = {1'b0, y};     neg_s = 1'b1; end
         // -0: all-ones PP plus the LSB correction cancels to zero
         CODE_M0:  begin mag_s = {(n+1){1'b0}}; neg_s = 1'b1; end
         default:  begin mag_s = {(n+1){1'b0}}; neg_s = 1'b0; end
      endcase
   end

   // One's complement for negative digits; the +1 is left to the caller
   always_comb begin
      if (neg_s) begin
         pp   = ~mag_s;
         sign = 1'b1;
      end else begin
         pp   = mag_s;
         sign = 1'b0;
      end
   end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier, one digit per clock.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only while idle)
//   a                    : multiplicand, n bits unsigned
//   b                    : multiplier, n bits unsigned (Booth-recoded)
//   out_valid / out_ready: product handshake, product held until taken
//   product              : a*b, 2n bits unsigned
module booth_seq_multiplier
   import booth_pkg::*;
#(
   parameter int n = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [n-1:0]   a,
   input  logic [n-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*n-1:0] product
);

   localparam int             D         = digit_count(n);
   localparam int             CW        = count_width(n);
   localparam logic [CW-1:0]  LAST_STEP = CW'(D - 1);

   state_t           state_r;
   logic [n-1:0]     a_r;
   logic [n+2:0]     recode_r;
   logic [CW-1:0]    cnt_r;
   logic [2*n+1:0]   acc_r;
   logic [2*n-1:0]   product_r;
   logic             in_ready_r;
   logic             out_valid_r;

   logic             enc_sign_s;
   logic [n:0]       enc_pp_s;
   logic [2*n+1:0]   term_s;
   logic [2*n+1:0]   acc_next_s;

   Booth_Encoder #(.n(n)) u_encoder (
      .x_high (recode_r[2]),
      .x      (recode_r[1]),
      .x_low  (recode_r[0]),
      .y      (a_r),
      .sign   (enc_sign_s),
      .pp     (enc_pp_s)
   );

   // Sign-extend {SIGN, PP}, add SIGN at the LSB, weight by 4^step
   always_comb begin
      term_s     = {{n{enc_sign_s}}, enc_sign_s, enc_pp_s}
                 + {{(2*n+1){1'b0}}, enc_sign_s};
      acc_next_s = acc_r + (term_s << {cnt_r, 1'b0});
   end

   // Controller, recode shifter, step counter, accumulator and outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         a_r         <= {n{1'b0}};
         recode_r    <= {(n+3){1'b0}};
         cnt_r       <= {CW{1'b0}};
         acc_r       <= {(2*n+2){1'b0}};
         product_r   <= {(2*n){1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready_r) begin
                  a_r        <= a;
                  recode_r   <= {2'b00, b, 1'b0};
                  cnt_r      <= {CW{1'b0}};
                  acc_r      <= {(2*n+2){1'b0}};
                  in_ready_r <= 1'b0;
                  state_r    <= RUN;
               end
            end
            RUN: begin
               acc_r    <= acc_next_s;
               recode_r <= {2'b00, recode_r[n+2:2]};
               cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               if (cnt_r == LAST_STEP) begin
                  product_r   <= acc_next_s[2*n-1:0];
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign product   = product_r;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
module tb_booth_seq_multiplier;

   localparam int N   = 8;
   localparam int LAT = N / 2 + 1;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] product;

   int pass_cnt  = 0;
   int total_cnt = 0;

   booth_seq_multiplier #(.n(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reference: plain unsigned multiplication
   function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
      return (2*N)'(x) * (2*N)'(y);
   endfunction

   // One complete operation; hold = cycles of out_ready low after out_valid,
   // toggle = wiggle in_valid/a/b during RUN, early = out_ready high in RUN
   task automatic run_op(input logic [N-1:0] xa, input logic [N-1:0] xb,
                         input int hold, input bit toggle, input bit early);
      logic [2*N-1:0] exp;
      int lat;
      bit seen;
      exp = ref_mul(xa, xb);
      @(negedge clk);
      check("in_ready_idle", 64'(in_ready), 64'd1);
      a = xa; b = xb; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (early) out_ready = 1'b1;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 20) begin
         check("in_ready_busy", 64'(in_ready), 64'd0);
         if (toggle) begin
            in_valid = ~in_valid;
            a = 8'($urandom); b = 8'($urandom);
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
         seen = out_valid;
      end
      in_valid = 1'b0;
      check("latency", 64'(lat), 64'(LAT));
      check("product", 64'(product), 64'(exp));
      check("acc_top", 64'(dut.acc_r[2*N+1 -: 2]), 64'd0);
      if (!early) begin
         for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_product", 64'(product), 64'(exp));
            check("hold_in_ready", 64'(in_ready), 64'd0);
         end
         out_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("valid_drop", 64'(out_valid), 64'd0);
      check("ready_back", 64'(in_ready), 64'd1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_product", 64'(product), 64'd0);
      rst_n = 1'b1;

      // Directed cases
      run_op(8'hA9, 8'h03, 0, 1'b0, 1'b0);
      check("const_1fb", 64'(product), 64'h01FB);
      run_op(8'hFF, 8'hFF, 0, 1'b0, 1'b0);
      check("const_fe01", 64'(product), 64'hFE01);
      run_op(8'hA9, 8'hB6, 0, 1'b0, 1'b0);
      check("const_7826", 64'(product), 64'h7826);
      run_op(8'h00, 8'hA5, 0, 1'b0, 1'b0);
      run_op(8'hA9, 8'h00, 0, 1'b0, 1'b0);
      run_op(8'h80, 8'h80, 0, 1'b0, 1'b0);
      run_op(8'hFF, 8'h01, 0, 1'b0, 1'b0);

      // Backpressure, in_valid toggling during RUN, early out_ready
      run_op(8'h5A, 8'hC3, 3, 1'b1, 1'b0);
      run_op(8'h37, 8'hE9, 0, 1'b0, 1'b1);

      // Asynchronous reset in the middle of RUN
      @(negedge clk);
      a = 8'hAB; b = 8'hCD; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_product", 64'(product), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h12, 8'h34, 0, 1'b0, 1'b0);
      check("const_3a8", 64'(product), 64'h03A8);

      // Randomized operands
      for (int i = 0; i < 25; i++) begin
         run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
                1'($urandom), 1'b0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
